// File: rtl/suma_pkg.sv
// Purpose: shared types and constants for the bit-serial add sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state encoding, default operand width, counter width helper.
package suma_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int WIDTH_DEF = 4;

  // Counter must hold 0..WIDTH; it is compared against WIDTH-1 in RUN.
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/sumador_completo.sv
// Purpose: one-bit full adder built from two half-adder cells and an OR.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of the inputs.
// Ports (sumador_medio):     i_x, i_y in; o_s sum, o_c carry.
// Ports (sumador_completo):  i_a, i_b, i_c in; o_s sum, o_c carry-out.

module sumador_medio (
  input  logic i_x,
  input  logic i_y,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_x ^ i_y;
  assign o_c = i_x & i_y;
endmodule

module sumador_completo (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);
  logic w_s1;
  logic w_c1;
  logic w_c2;

  sumador_medio u_ha0 (
    .i_x (i_a),
    .i_y (i_b),
    .o_s (w_s1),
    .o_c (w_c1)
  );

  sumador_medio u_ha1 (
    .i_x (w_s1),
    .i_y (i_c),
    .o_s (o_s),
    .o_c (w_c2)
  );

  // Both half-adder carries can never be 1 together, so OR is exact.
  assign o_c = w_c1 | w_c2;
endmodule

// File: rtl/control_suma_serie.sv
// Purpose: bit-serial adder, one full-adder cell stepped WIDTH times LSB first.
// Latency: start accepted at edge k -> done pulses in the cycle after edge k+WIDTH+1.
// Backpressure: start is ignored while busy=1; accepted in IDLE and in DONE.
// Ports: clk, rst_n (async active-low); start, a, b, cin in;
//        busy, done (1-cycle pulse), suma, cout out; ovf out when SUMA_OVF_EN is defined.
// Optional feature macro: SUMA_OVF_EN adds the signed-overflow flag ovf.
module control_suma_serie
  import suma_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] suma,
  output logic             cout
`ifdef SUMA_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_suma;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic             r_cout;
`ifdef SUMA_OVF_EN
  logic             r_ovf;
`endif

  logic w_s;
  logic w_c;

  sumador_completo u_fa (
    .i_a (r_a[0]),
    .i_b (r_b[0]),
    .i_c (r_carry),
    .o_s (w_s),
    .o_c (w_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_suma  <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cout  <= 1'b0;
`ifdef SUMA_OVF_EN
      r_ovf   <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end

        S_RUN: begin
          // Result bits enter at the MSB and walk down, so after WIDTH
          // steps the first (LSB) sum bit has reached suma[0].
          r_a     <= {1'b0, r_a[WIDTH-1:1]};
          r_b     <= {1'b0, r_b[WIDTH-1:1]};
          r_suma  <= {w_s, r_suma[WIDTH-1:1]};
          r_carry <= w_c;
          r_cnt   <= r_cnt + CW'(1);
          if (r_cnt == CNT_LAST) begin
            r_busy  <= 1'b0;
            r_state <= S_DONE;
`ifdef SUMA_OVF_EN
            // r_carry is the carry into the MSB, w_c the carry out of it.
            r_ovf   <= r_carry ^ w_c;
`endif
          end
        end

        S_DONE: begin
          // done/cout register here; suma stays put until the first RUN
          // step of the next operation, so it is valid alongside done.
          r_done <= 1'b1;
          r_cout <= r_carry;
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign suma = r_suma;
  assign cout = r_cout;
`ifdef SUMA_OVF_EN
  assign ovf  = r_ovf;
`endif

endmodule
